// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Single-outstanding instruction fetch stage with IR, redirect and
//            sticky fault reporting.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
   parameter logic [31:0] RESET_PC       = 32'h0000_0000,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fetch_en,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   input  logic        imem_resp_err,
   output logic [31:0] ir,
   output logic [6:0]  opcode,
   output logic [2:0]  funct3,
   output logic [6:0]  funct7,
   output logic [31:0] instr_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        fault,
   output logic [1:0]  fault_cause
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_WAIT  = 3'd2,
      S_HOLD  = 3'd3,
      S_FAULT = 3'd4
   } state_t;

   localparam logic [7:0] c_timeout_last = 8'(TIMEOUT_CYCLES - 1);
   localparam logic [1:0] c_cause_bus    = 2'd1;
   localparam logic [1:0] c_cause_tmo    = 2'd2;
   localparam logic [1:0] c_cause_align  = 2'd3;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_ir;
   logic [31:0] r_instr_pc;
   logic        r_instr_valid;
   logic        r_fault;
   logic [1:0]  r_fault_cause;
   logic        r_kill;
   logic [7:0]  r_timer;

   logic        w_misaligned;
   state_t      w_resume;

   assign w_misaligned = (redirect_pc[1:0] != 2'b00);
   assign w_resume     = fetch_en ? S_REQ : S_IDLE;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_pc          <= RESET_PC;
         r_ir          <= 32'd0;
         r_instr_pc    <= 32'd0;
         r_instr_valid <= 1'b0;
         r_fault       <= 1'b0;
         r_fault_cause <= 2'd0;
         r_kill        <= 1'b0;
         r_timer       <= 8'd0;
      end else if (redirect_valid && (r_state != S_FAULT)) begin
         // Redirect wins over every other event in the cycle.
         r_pc          <= redirect_pc;
         r_instr_valid <= 1'b0;
         if (w_misaligned) begin
            r_state       <= S_FAULT;
            r_fault       <= 1'b1;
            r_fault_cause <= c_cause_align;
         end else begin
            case (r_state)
               S_REQ: begin
                  if (imem_req_ready) begin
                     r_state <= S_WAIT;
                     r_kill  <= 1'b1;
                     r_timer <= 8'd0;
                  end
               end
               S_WAIT: begin
                  r_kill  <= 1'b1;
                  r_timer <= r_timer + 8'd1;
               end
               S_HOLD:  r_state <= w_resume;
               default: ;
            endcase
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               if (fetch_en) r_state <= S_REQ;
            end
            S_REQ: begin
               if (imem_req_ready) begin
                  r_state <= S_WAIT;
                  r_timer <= 8'd0;
               end
            end
            S_WAIT: begin
               r_timer <= r_timer + 8'd1;
               if (imem_resp_valid) begin
                  if (r_kill) begin
                     r_kill  <= 1'b0;
                     r_state <= w_resume;
                  end else if (imem_resp_err) begin
                     r_state       <= S_FAULT;
                     r_fault       <= 1'b1;
                     r_fault_cause <= c_cause_bus;
                  end else begin
                     r_ir          <= imem_resp_data;
                     r_instr_pc    <= r_pc;
                     r_instr_valid <= 1'b1;
                     r_state       <= S_HOLD;
                  end
               end else if (r_timer >= c_timeout_last) begin
                  // >= so a timer pushed past the limit by a redirect still trips
                  r_state       <= S_FAULT;
                  r_fault       <= 1'b1;
                  r_fault_cause <= c_cause_tmo;
               end
            end
            S_HOLD: begin
               if (instr_ready) begin
                  r_instr_valid <= 1'b0;
                  r_pc          <= r_pc + 32'd4;
                  r_state       <= w_resume;
               end
            end
            S_FAULT: begin
               r_instr_valid <= 1'b0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign imem_req_valid = (r_state == S_REQ);
   assign imem_req_addr  = r_pc;
   assign ir             = r_ir;
   assign opcode         = r_ir[6:0];
   assign funct3         = r_ir[14:12];
   assign funct7         = r_ir[31:25];
   assign instr_pc       = r_instr_pc;
   assign instr_valid    = r_instr_valid;
   assign fault          = r_fault;
   assign fault_cause    = r_fault_cause;

endmodule
`default_nettype wire
